// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are reduced to magnitudes on accept, multiplied unsigned over
// WIDTH cycles with a single WIDTH+1-bit adder, and the sign is re-applied on the
// last iteration. Valid/ready handshake on both the operand and the product side.
module seq_mult_param #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               neg_q, neg_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits W unsigned bits.
   always_comb begin
      a_mag = (signed_en && a[WIDTH-1]) ? ('0 - a) : a;
      b_mag = (signed_en && b[WIDTH-1]) ? ('0 - b) : b;
   end

   // One shift-add step: conditional add into the upper half, then shift
   // {carry, acc, mplier} right by one (the multiplier LSB drops out).
   always_comb begin
      sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      prod = {sum, mplier_q[WIDTH-1:1]};
   end

   // Next-state and datapath update; all registers hold by default.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = CW'(WIDTH - 1);
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d    = prod[2*WIDTH-1:WIDTH];
            mplier_d = prod[WIDTH-1:0];
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               p_d     = neg_q ? ('0 - prod) : prod;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
      end
   end

   // Handshake and status outputs decode the state directly.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q == S_BUSY);
      p         = p_q;
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed table, exhaustive W=4, random W=8 and handshake
// corner sequences for seq_mult_param.
module tb_seq_mult_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       in_valid4, in_ready4, signed_en4, out_valid4, out_ready4, busy4;
   logic [3:0] a4, b4;
   logic [7:0] p4;

   logic        in_valid8, in_ready8, signed_en8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   seq_mult_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .signed_en(signed_en4), .out_valid(out_valid4),
      .out_ready(out_ready4), .p(p4), .busy(busy4)
   );

   seq_mult_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .signed_en(signed_en8), .out_valid(out_valid8),
      .out_ready(out_ready8), .p(p8), .busy(busy8)
   );

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       s;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference product from a native signed/unsigned multiply.
   function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] y,
                                            input logic s, input int unsigned w);
      logic signed [15:0] sx, sy;
      logic [15:0] r;
      if (w == 4) begin
         sx = s ? 16'($signed(x[3:0])) : 16'(x[3:0]);
         sy = s ? 16'($signed(y[3:0])) : 16'(y[3:0]);
         r  = 16'(sx * sy);
         return {8'h00, r[7:0]};
      end
      sx = s ? 16'($signed(x)) : 16'(x);
      sy = s ? 16'($signed(y)) : 16'(y);
      return 16'(sx * sy);
   endfunction

   task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic s,
                      input int gap_in, input int gap_out,
                      output logic [7:0] res, output int lat);
      int n;
      repeat (gap_in) begin @(posedge clk); #1; end
      n = 0;
      while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready4) check("op4_ready_timeout", 16'(in_ready4), 16'd1);
      a4 = ta; b4 = tb; signed_en4 = s; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0; a4 = ~ta; b4 = ~tb; signed_en4 = ~s;
      lat = 0;
      while (!out_valid4 && lat < 50) begin @(posedge clk); #1; lat++; end
      res = p4;
      repeat (gap_out) begin @(posedge clk); #1; end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic s,
                      input int gap_in, input int gap_out,
                      output logic [15:0] res, output int lat);
      int n;
      repeat (gap_in) begin @(posedge clk); #1; end
      n = 0;
      while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready8) check("op8_ready_timeout", 16'(in_ready8), 16'd1);
      a8 = ta; b8 = tb; signed_en8 = s; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); signed_en8 = ~s;
      lat = 0;
      while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
      res = p8;
      repeat (gap_out) begin
         @(posedge clk); #1;
         check("op8_hold_p", p8, res);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  r4;
      logic [15:0] r8;
      int          lat;
      int          n;

      rst = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; signed_en4 = 1'b0; out_ready4 = 1'b0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; signed_en8 = 1'b0; out_ready8 = 1'b0;
      #12;
      check("reset4", 16'({out_valid4, in_ready4, busy4, p4}), 16'({1'b0, 1'b1, 1'b0, 8'h00}));
      check("reset8_p", p8, 16'h0000);
      check("reset8_ctl", 16'({out_valid8, in_ready8, busy8}), 16'(3'b010));
      rst = 1'b0;
      @(posedge clk); #1;

      tbl[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
      tbl[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
      tbl[2]  = '{4'hD, 4'h5, 1'b1, 8'hF1};
      tbl[3]  = '{4'h0, 4'h9, 1'b0, 8'h00};
      tbl[4]  = '{4'h0, 4'hD, 1'b1, 8'h00};
      tbl[5]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
      tbl[6]  = '{4'h8, 4'h8, 1'b0, 8'h40};
      tbl[7]  = '{4'hF, 4'hF, 1'b1, 8'h01};
      tbl[8]  = '{4'hF, 4'h1, 1'b1, 8'hFF};
      tbl[9]  = '{4'h7, 4'h7, 1'b1, 8'h31};
      tbl[10] = '{4'h9, 4'h3, 1'b0, 8'h1B};
      tbl[11] = '{4'h3, 4'hC, 1'b1, 8'hF4};
      tbl[12] = '{4'h8, 4'h1, 1'b1, 8'hF8};
      tbl[13] = '{4'h1, 4'h0, 1'b1, 8'h00};

      for (int i = 0; i < 14; i++) begin
         op4(tbl[i].a, tbl[i].b, tbl[i].s, 0, i % 3, r4, lat);
         check("tbl_p", 16'(r4), 16'(tbl[i].exp));
         check("tbl_latency", 16'(lat), 16'd4);
      end

      // Exhaustive W=4, both modes.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               op4(4'(i), 4'(j), 1'(s), 0, 0, r4, lat);
               check("exh4_p", 16'(r4), ref_mult(8'(i), 8'(j), 1'(s), 4));
               check("exh4_latency", 16'(lat), 16'd4);
            end
         end
      end

      // Backpressure: product and handshake hold while out_ready is low.
      a4 = 4'hF; b4 = 4'hF; signed_en4 = 1'b0; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 50) begin @(posedge clk); #1; n++; end
      check("bp_latency", 16'(n), 16'd4);
      for (int k = 0; k < 10; k++) begin
         check("bp_hold", 16'({out_valid4, in_ready4, p4}), 16'({1'b1, 1'b0, 8'hE1}));
         @(posedge clk); #1;
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check("bp_release", 16'({out_valid4, in_ready4, busy4, p4}),
            16'({1'b0, 1'b1, 1'b0, 8'hE1}));

      // Second request held during BUSY must be ignored.
      a4 = 4'hD; b4 = 4'h5; signed_en4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      a4 = 4'h1; b4 = 4'h1; signed_en4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 50) begin
         check("ignore_ready_low", 16'(in_ready4), 16'd0);
         @(posedge clk); #1; n++;
      end
      in_valid4 = 1'b0;
      check("ignore_p", 16'(p4), 16'h00F1);
      check("ignore_latency", 16'(n), 16'd4);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      @(posedge clk); #1;
      check("ignore_idle", 16'({in_ready4, busy4, out_valid4}), 16'(3'b100));

      // in_valid pulse that never meets a clock edge.
      #2 in_valid4 = 1'b1;
      #2 in_valid4 = 1'b0;
      @(posedge clk); #1;
      check("valid_drop", 16'({in_ready4, busy4}), 16'(2'b10));

      // Reset two cycles into an operation.
      a4 = 4'h7; b4 = 4'h7; signed_en4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_busy", 16'(busy4), 16'd1);
      #2 rst = 1'b1;
      #1;
      check("midop_reset", 16'({out_valid4, in_ready4, busy4, p4}),
            16'({1'b0, 1'b1, 1'b0, 8'h00}));
      #2 rst = 1'b0;
      @(posedge clk); #1;
      op4(4'h3, 4'hC, 1'b1, 0, 0, r4, lat);
      check("post_reset_p", 16'(r4), 16'h00F4);
      check("post_reset_latency", 16'(lat), 16'd4);

      // W=8 corners.
      op8(8'h80, 8'h80, 1'b1, 0, 0, r8, lat);
      check("w8_minmin", r8, 16'h4000);
      check("w8_latency", 16'(lat), 16'd8);
      op8(8'hFF, 8'hFF, 1'b0, 1, 2, r8, lat);
      check("w8_maxmax", r8, 16'hFE01);
      op8(8'h80, 8'h7F, 1'b1, 0, 0, r8, lat);
      check("w8_minmax", r8, 16'hC080);

      // Random W=8 with random valid/ready gaps.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rs;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         op8(ra, rb, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r8, lat);
         check("rnd8_p", r8, ref_mult(ra, rb, rs, 8));
         check("rnd8_latency", 16'(lat), 16'd8);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
